// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared state type and address map for the cartridge bus controller
//
// Purpose: holds the controller state enum, the cartridge address-map
// boundaries and the small decode helpers used by cart_bus_ctrl.
// Ports: none (package).

package cart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BOOT   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } cart_state_e;

  localparam logic [15:0] ROM_END   = 16'h7FFF;
  localparam logic [15:0] ERAM_BASE = 16'hA000;
  localparam logic [15:0] ERAM_END  = 16'hBFFF;
  localparam logic [15:0] BOOT_END  = 16'h00FF;

  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

  // External RAM window; the only region that selects the cart chip-select.
  function automatic logic is_eram(input logic [15:0] a);
    return (a >= ERAM_BASE) && (a <= ERAM_END);
  endfunction

  // Everything the cartridge answers for: ROM plus external RAM.
  function automatic logic is_cart_space(input logic [15:0] a);
    return (a <= ROM_END) || is_eram(a);
  endfunction

endpackage

// File: rtl/cart_bus_ctrl.sv
// rtl/cart_bus_ctrl.sv - CPU-to-cartridge bus sequencer with boot ROM overlay
//
// Purpose: accepts single CPU read/write requests and either answers them
// from the boot overlay, runs a timed cartridge bus cycle
// (SETUP -> STROBE -> HOLD), or returns open-bus data for unmapped space.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cpu_en                CPU clock enable; requests sampled only when high
//   req_rd, req_wr        CPU read / write request (exactly one must be high)
//   addr[15:0], wdata[7:0] CPU address and write data
//   rdata[7:0], busy      read result, transaction in progress
//   use_cart              high disables the boot overlay
//   boot_addr[7:0], boot_rdata[7:0]  boot ROM address out / data in
//   cart_addr[15:0], cart_dout[7:0], cart_doe, cart_din[7:0]  cart data path
//   cart_rd_n, cart_wr_n, cart_cs_n  active-low cart strobes

module cart_bus_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  input  logic        use_cart,
  output logic [7:0]  boot_addr,
  input  logic [7:0]  boot_rdata,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_dout,
  output logic        cart_doe,
  input  logic [7:0]  cart_din,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n
);

  import cart_pkg::*;

  // Dwell counter is loaded with N-1 so that a zero in the dwell state means
  // "this is the last cycle of the phase".
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

  cart_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        is_eram_q, is_eram_d;
  logic [15:0] cart_addr_q, cart_addr_d;
  logic [7:0]  cart_dout_q, cart_dout_d;
  logic [7:0]  boot_addr_q, boot_addr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        cart_rd_n_q, cart_rd_n_d;
  logic        cart_wr_n_q, cart_wr_n_d;
  logic        cart_cs_n_q, cart_cs_n_d;
  logic        cart_doe_q, cart_doe_d;

  logic        accept;
  logic        acc_boot;
  logic        acc_cart;
  logic        in_cycle_d;

  // Request decode. Boot overlay wins over ROM for reads only; writes in
  // cart space always reach the cartridge so MBC registers stay reachable.
  always_comb begin
    accept   = (state_q == IDLE) && cpu_en && (req_rd ^ req_wr);
    acc_boot = accept && req_rd && !use_cart && (addr <= BOOT_END);
    acc_cart = accept && !acc_boot && is_cart_space(addr);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    is_eram_d   = is_eram_q;
    cart_addr_d = cart_addr_q;
    cart_dout_d = cart_dout_q;
    boot_addr_d = boot_addr_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (acc_boot) begin
          state_d     = BOOT;
          boot_addr_d = addr[7:0];
        end else if (acc_cart) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LOAD;
          cart_addr_d = addr;
          cart_dout_d = wdata;
          is_wr_d     = req_wr;
          is_eram_d   = is_eram(addr);
        end else if (accept) begin
          // Unmapped space: no bus cycle, open-bus value on the next cycle.
          rdata_d = OPEN_BUS;
        end
      end

      BOOT: begin
        rdata_d = boot_rdata;
        state_d = IDLE;
      end

      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          // Cart data is taken on the final strobe cycle, while rd_n is low.
          if (!is_wr_q) begin
            rdata_d = cart_din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Bus outputs are registered from the next state so the strobes come
    // straight off flops and cannot glitch on state decode.
    in_cycle_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    busy_d      = (state_d != IDLE);
    cart_rd_n_d = !((state_d == STROBE) && !is_wr_d);
    cart_wr_n_d = !((state_d == STROBE) && is_wr_d);
    cart_cs_n_d = !(in_cycle_d && is_eram_d);
    cart_doe_d  = in_cycle_d && is_wr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_wr_q     <= 1'b0;
      is_eram_q   <= 1'b0;
      cart_addr_q <= 16'h0000;
      cart_dout_q <= 8'h00;
      boot_addr_q <= 8'h00;
      rdata_q     <= OPEN_BUS;
      busy_q      <= 1'b0;
      cart_rd_n_q <= 1'b1;
      cart_wr_n_q <= 1'b1;
      cart_cs_n_q <= 1'b1;
      cart_doe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      is_eram_q   <= is_eram_d;
      cart_addr_q <= cart_addr_d;
      cart_dout_q <= cart_dout_d;
      boot_addr_q <= boot_addr_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      cart_rd_n_q <= cart_rd_n_d;
      cart_wr_n_q <= cart_wr_n_d;
      cart_cs_n_q <= cart_cs_n_d;
      cart_doe_q  <= cart_doe_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign boot_addr = boot_addr_q;
  assign cart_addr = cart_addr_q;
  assign cart_dout = cart_dout_q;
  assign cart_doe  = cart_doe_q;
  assign cart_rd_n = cart_rd_n_q;
  assign cart_wr_n = cart_wr_n_q;
  assign cart_cs_n = cart_cs_n_q;

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// tb/tb_cart_bus_ctrl.sv - self-checking bench for cart_bus_ctrl

module tb_cart_bus_ctrl;

  localparam int S = 1;
  localparam int T = 3;
  localparam int L = S + T + 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        use_cart;
  logic [7:0]  boot_addr;
  logic [7:0]  boot_rdata;
  logic [15:0] cart_addr;
  logic [7:0]  cart_dout;
  logic        cart_doe;
  logic [7:0]  cart_din;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;

  always #5 clk = ~clk;

  cart_bus_ctrl #(.SETUP_CYC(S), .STROBE_CYC(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .use_cart   (use_cart),
    .boot_addr  (boot_addr),
    .boot_rdata (boot_rdata),
    .cart_addr  (cart_addr),
    .cart_dout  (cart_dout),
    .cart_doe   (cart_doe),
    .cart_din   (cart_din),
    .cart_rd_n  (cart_rd_n),
    .cart_wr_n  (cart_wr_n),
    .cart_cs_n  (cart_cs_n)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  ref_rdata;
  logic [15:0] bnd [0:7];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_cart_space(input logic [15:0] a);
    return (a < 16'h8000) || ((a >= 16'hA000) && (a < 16'hC000));
  endfunction

  // One CPU request followed by a fixed observation window; the expected bus
  // behaviour is derived from the address map and cycle budget alone.
  task automatic run_txn(input logic rd, input logic wr, input logic en,
                         input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input logic [7:0] brd,
                         input logic uc, input bit hold_req, input string name);
    bit accepted, boot, cart, oor, eram;
    int exp_busy;
    int busy_n, busy_first, rd_lo, wr_lo, cs_lo, doe_hi;
    int strobe_first, pulses, addr_bad, dout_bad, baddr_bad;
    bit lo, prev_lo;

    accepted = en && (rd != wr);
    boot     = accepted && rd && !uc && (a < 16'h0100);
    cart     = accepted && !boot && in_cart_space(a);
    oor      = accepted && !in_cart_space(a);
    eram     = (a >= 16'hA000) && (a < 16'hC000);
    exp_busy = cart ? (S + T + 1) : (boot ? 1 : 0);

    if (cart && rd)  ref_rdata = din;
    else if (boot)   ref_rdata = brd;
    else if (oor)    ref_rdata = 8'hFF;

    busy_n = 0; busy_first = -1; rd_lo = 0; wr_lo = 0; cs_lo = 0; doe_hi = 0;
    strobe_first = -1; pulses = 0; addr_bad = 0; dout_bad = 0; baddr_bad = 0;
    prev_lo = 1'b0;

    @(posedge clk); #1;
    cpu_en = en; req_rd = rd; req_wr = wr; addr = a; wdata = wd;
    cart_din = din; boot_rdata = brd; use_cart = uc;

    for (int k = 0; k < L; k++) begin
      @(posedge clk); #1;
      if (k == 0) use_cart = ~uc;
      if (hold_req && k < 3) begin
        addr = a ^ 16'h0100;
      end else begin
        req_rd = 1'b0;
        req_wr = 1'b0;
        cpu_en = 1'b1;
      end
      if (busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = k;
        if (cart && cart_addr !== a) addr_bad++;
        if (cart && wr && cart_dout !== wd) dout_bad++;
        if (boot && boot_addr !== a[7:0]) baddr_bad++;
      end
      lo = !cart_rd_n || !cart_wr_n;
      if (lo && strobe_first < 0) strobe_first = k;
      if (lo && !prev_lo) pulses++;
      prev_lo = lo;
      if (!cart_rd_n) rd_lo++;
      if (!cart_wr_n) wr_lo++;
      if (!cart_cs_n) cs_lo++;
      if (cart_doe)   doe_hi++;
    end

    check({name, ":busy_cycles"}, busy_n, exp_busy);
    if (exp_busy > 0) check({name, ":busy_start"}, busy_first, 0);
    check({name, ":rd_low"},  rd_lo,  (cart && rd) ? T : 0);
    check({name, ":wr_low"},  wr_lo,  (cart && wr) ? T : 0);
    check({name, ":cs_low"},  cs_lo,  (cart && eram) ? (S + T + 1) : 0);
    check({name, ":doe_high"}, doe_hi, (cart && wr) ? (S + T + 1) : 0);
    check({name, ":pulses"},  pulses, cart ? 1 : 0);
    if (cart) begin
      check({name, ":setup_len"}, strobe_first, S);
      check({name, ":addr_stable"}, addr_bad, 0);
      if (wr) check({name, ":dout"}, dout_bad, 0);
    end
    if (boot) check({name, ":boot_addr"}, baddr_bad, 0);
    check({name, ":rdata"}, rdata, ref_rdata);
  endtask

  initial begin
    bit found;
    logic [15:0] a;
    logic        rd, wr, en;
    int          r;

    bnd[0] = 16'h00FF; bnd[1] = 16'h0100; bnd[2] = 16'h7FFF; bnd[3] = 16'h8000;
    bnd[4] = 16'h9FFF; bnd[5] = 16'hA000; bnd[6] = 16'hBFFF; bnd[7] = 16'hC000;

    reset = 1'b1; cpu_en = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = 16'h0;
    wdata = 8'h0; use_cart = 1'b0; boot_rdata = 8'h0; cart_din = 8'h0;
    ref_rdata = 8'hFF;
    #12;
    check("reset:busy",      busy, 0);
    check("reset:rdata",     rdata, 8'hFF);
    check("reset:rd_n",      cart_rd_n, 1);
    check("reset:wr_n",      cart_wr_n, 1);
    check("reset:cs_n",      cart_cs_n, 1);
    check("reset:doe",       cart_doe, 0);
    check("reset:cart_addr", cart_addr, 16'h0000);
    check("reset:cart_dout", cart_dout, 8'h00);
    check("reset:boot_addr", boot_addr, 8'h00);
    @(negedge clk); reset = 1'b0; cpu_en = 1'b1;

    run_txn(1, 0, 1, 16'h0042, 8'h00, 8'h00, 8'h31, 0, 0, "boot_0042");
    run_txn(1, 0, 1, 16'h0042, 8'h00, 8'hC3, 8'h31, 1, 0, "cart_rd_0042");
    run_txn(0, 1, 1, 16'h2000, 8'h05, 8'h00, 8'h00, 1, 0, "wr_2000");
    run_txn(0, 1, 1, 16'hA123, 8'h7E, 8'h00, 8'h00, 1, 0, "wr_A123");
    run_txn(1, 1, 1, 16'h1234, 8'h11, 8'h22, 8'h33, 1, 0, "both_req");
    run_txn(1, 0, 1, 16'hC000, 8'h00, 8'h44, 8'h55, 1, 0, "rd_C000");
    run_txn(1, 0, 1, 16'h4000, 8'h00, 8'h5A, 8'h00, 1, 1, "held_req");
    run_txn(1, 0, 0, 16'h0100, 8'h00, 8'h66, 8'h77, 1, 0, "cpu_en_low");
    run_txn(0, 1, 1, 16'h0010, 8'h9C, 8'h00, 8'hEE, 0, 0, "wr_boot_area");
    run_txn(1, 0, 1, 16'h00FF, 8'h00, 8'h12, 8'hA5, 0, 0, "boot_00FF");
    run_txn(1, 0, 1, 16'h0100, 8'h00, 8'h3C, 8'hA5, 0, 0, "rd_0100");
    run_txn(1, 0, 1, 16'h7FFF, 8'h00, 8'h81, 8'h00, 1, 0, "rd_7FFF");
    run_txn(1, 0, 1, 16'h8000, 8'h00, 8'h82, 8'h00, 1, 0, "rd_8000");
    run_txn(1, 0, 1, 16'hBFFF, 8'h00, 8'h83, 8'h00, 1, 0, "rd_BFFF");
    run_txn(0, 1, 1, 16'h9FFF, 8'h84, 8'h00, 8'h00, 1, 0, "wr_9FFF");

    // Reset landing in the middle of a write strobe.
    @(posedge clk); #1;
    cpu_en = 1'b1; req_wr = 1'b1; addr = 16'h2000; wdata = 8'h99;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      req_wr = 1'b0;
      if (!cart_wr_n) found = 1'b1;
    end
    check("rst_mid:strobe_seen", found, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid:wr_n",      cart_wr_n, 1);
    check("rst_mid:rd_n",      cart_rd_n, 1);
    check("rst_mid:cs_n",      cart_cs_n, 1);
    check("rst_mid:doe",       cart_doe, 0);
    check("rst_mid:busy",      busy, 0);
    check("rst_mid:rdata",     rdata, 8'hFF);
    check("rst_mid:cart_addr", cart_addr, 16'h0000);
    ref_rdata = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    run_txn(1, 0, 1, 16'h3456, 8'h00, 8'h6D, 8'h00, 1, 0, "after_reset");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'($urandom_range(0, 16'h01FF));
        1: a = 16'($urandom_range(0, 16'h7FFF));
        2: a = 16'($urandom_range(16'hA000, 16'hBFFF));
        3: a = 16'($urandom_range(16'h8000, 16'h9FFF));
        4: a = 16'($urandom_range(16'hC000, 16'hFFFF));
        default: a = bnd[$urandom_range(0, 7)];
      endcase
      r  = $urandom_range(0, 19);
      rd = (r < 9) || (r == 18);
      wr = ((r >= 9) && (r < 18)) || (r == 18);
      en = ($urandom_range(0, 9) != 0);
      run_txn(rd, wr, en, a, 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
